// File: rtl/pio_clkdiv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pio_clkdiv_pkg                                             |
// | Description : Shared constants and the effective-divisor helper for the  |
// |               PIO fractional clock-enable generator.                     |
// |               DEF_INT_W / DEF_FRAC_W : default divisor field widths      |
// |               ONE                    : 1.0 in fixed point (2^FRAC_W)     |
// |               ACC_W                  : accumulator / divisor width       |
// |               eff_div()              : int==0 -> maximum divide rule     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package pio_clkdiv_pkg;

  localparam int DEF_INT_W  = 16;
  localparam int DEF_FRAC_W = 8;
  localparam int ONE        = 1 << DEF_FRAC_W;
  localparam int ACC_W      = DEF_INT_W + DEF_FRAC_W + 1;

  // Wide enough for any channel configuration; callers size-cast the result
  // down to their own accumulator width.
  localparam int EFF_MAX_W  = 64;

  // Effective divisor in fixed point. int==0 selects 2^(int_w+frac_w), the
  // slowest rate representable, and the fraction is ignored in that case.
  function automatic logic [EFF_MAX_W-1:0] eff_div(
    input logic [EFF_MAX_W-1:0] int_v,
    input logic [EFF_MAX_W-1:0] frac_v,
    input int unsigned          int_w,
    input int unsigned          frac_w
  );
    logic [EFF_MAX_W-1:0] r;
    if (int_v == '0) begin
      r = {{(EFF_MAX_W-1){1'b0}}, 1'b1} << (int_w + frac_w);
    end else begin
      r = (int_v << frac_w) | frac_v;
    end
    return r;
  endfunction

endpackage : pio_clkdiv_pkg
`default_nettype wire

// File: rtl/pio_clkdiv_multi_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pio_clkdiv_multi_if                                        |
// | Description : Configuration / strobe bundle between the divider register |
// |               block (master) and the clock-enable generator (slave).     |
// |               en, restart   : per-channel run enable / phase restart     |
// |               div_int       : packed integer divisors, ch i at i*INT_W   |
// |               div_frac      : packed fraction divisors, ch i at i*FRAC_W |
// |               phase_init    : packed restart phases (PIO_CLKDIV_PHASE_EN)|
// |               penable       : per-channel one-clk enable strobes         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface pio_clkdiv_multi_if #(
  parameter int NUM_CH = 4,
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8
);
  logic [NUM_CH-1:0]        en;
  logic [NUM_CH-1:0]        restart;
  logic [NUM_CH*INT_W-1:0]  div_int;
  logic [NUM_CH*FRAC_W-1:0] div_frac;
`ifdef PIO_CLKDIV_PHASE_EN
  logic [NUM_CH*(INT_W+FRAC_W)-1:0] phase_init;
`endif
  logic [NUM_CH-1:0]        penable;

  modport master (
    output en, restart, div_int, div_frac,
`ifdef PIO_CLKDIV_PHASE_EN
    output phase_init,
`endif
    input  penable
  );

  modport slave (
    input  en, restart, div_int, div_frac,
`ifdef PIO_CLKDIV_PHASE_EN
    input  phase_init,
`endif
    output penable
  );

endinterface : pio_clkdiv_multi_if
`default_nettype wire

// File: rtl/pio_clkdiv_chan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pio_clkdiv_chan                                            |
// | Description : One fractional clock-enable channel: accumulator, shadow   |
// |               divisor and registered strobe.                             |
// |               clk, reset     : clock, async active-high reset            |
// |               i_en           : run enable                                |
// |               i_restart      : phase restart strobe (overrides i_en)     |
// |               i_div_int/frac : divisor inputs                            |
// |               i_phase_init   : restart phase (PIO_CLKDIV_PHASE_EN only)  |
// |               o_penable      : one-clk enable strobe                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pio_clkdiv_chan
  import pio_clkdiv_pkg::*;
#(
  parameter int INT_W  = DEF_INT_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_en,
  input  logic                    i_restart,
  input  logic [INT_W-1:0]        i_div_int,
  input  logic [FRAC_W-1:0]       i_div_frac,
`ifdef PIO_CLKDIV_PHASE_EN
  input  logic [INT_W+FRAC_W-1:0] i_phase_init,
`endif
  output logic                    o_penable
);

  localparam int                 CH_ACC_W = INT_W + FRAC_W + 1;
  localparam logic [CH_ACC_W-1:0] CH_ONE  = CH_ACC_W'(1) << FRAC_W;

  logic [CH_ACC_W-1:0] cnt_q, cnt_d;
  logic [CH_ACC_W-1:0] div_q, div_d;
  logic                penable_q, penable_d;

  logic [CH_ACC_W-1:0] w_d_eff;
  logic [CH_ACC_W-1:0] w_nxt;
  logic [CH_ACC_W-1:0] w_restart_cnt;

  // The extra accumulator bit means cnt + ONE never wraps: cnt < D <= 2^(I+F).
  assign w_d_eff = CH_ACC_W'(eff_div(EFF_MAX_W'(i_div_int), EFF_MAX_W'(i_div_frac),
                                     INT_W, FRAC_W));
  assign w_nxt   = cnt_q + CH_ONE;

`ifdef PIO_CLKDIV_PHASE_EN
  logic [CH_ACC_W-1:0] w_phase;
  assign w_phase = CH_ACC_W'(i_phase_init);

  // Clamp against the divisor loaded in the same cycle so cnt < D still holds.
  always_comb begin
    w_restart_cnt = w_phase;
    if (w_phase >= w_d_eff) begin
      w_restart_cnt = w_d_eff - CH_ACC_W'(1);
    end
  end
`else
  assign w_restart_cnt = '0;
`endif

  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    penable_d = 1'b0;
    if (i_restart) begin
      cnt_d = w_restart_cnt;
      div_d = w_d_eff;
    end else if (!i_en) begin
      // Stopped: the shadow follows the inputs so a later start uses them.
      div_d = w_d_eff;
    end else if (w_nxt >= div_q) begin
      // The shadow is only refreshed on a strobe; the residue nxt-D is below
      // ONE, which is below any legal new divisor, so no short interval.
      penable_d = 1'b1;
      cnt_d     = w_nxt - div_q;
      div_d     = w_d_eff;
    end else begin
      cnt_d = w_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      div_q     <= CH_ONE;
      penable_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      penable_q <= penable_d;
    end
  end

  assign o_penable = penable_q;

endmodule : pio_clkdiv_chan
`default_nettype wire

// File: rtl/pio_clkdiv_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pio_clkdiv_multi                                           |
// | Description : NUM_CH independent fractional clock-enable generators for  |
// |               the PIO state-machine array. Each channel strobes at       |
// |               clk / (div_int + div_frac/2^FRAC_W); div_int==0 selects    |
// |               the maximum divide 2^INT_W.                                |
// |               clk   : system clock                                       |
// |               reset : asynchronous active-high reset                     |
// |               bus   : slave side of pio_clkdiv_multi_if                  |
// |               Optional macro PIO_CLKDIV_PHASE_EN adds phase_init, loaded |
// |               (clamped to D-1) into the accumulator on restart.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pio_clkdiv_multi
  import pio_clkdiv_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int INT_W  = DEF_INT_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic                clk,
  input  logic                reset,
  pio_clkdiv_multi_if.slave   bus
);

  logic [NUM_CH-1:0] w_penable;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      pio_clkdiv_chan #(
        .INT_W  (INT_W),
        .FRAC_W (FRAC_W)
      ) u_chan (
        .clk          (clk),
        .reset        (reset),
        .i_en         (bus.en[i]),
        .i_restart    (bus.restart[i]),
        .i_div_int    (bus.div_int[i*INT_W +: INT_W]),
        .i_div_frac   (bus.div_frac[i*FRAC_W +: FRAC_W]),
`ifdef PIO_CLKDIV_PHASE_EN
        .i_phase_init (bus.phase_init[i*(INT_W+FRAC_W) +: (INT_W+FRAC_W)]),
`endif
        .o_penable    (w_penable[i])
      );
    end
  endgenerate

  assign bus.penable = w_penable;

endmodule : pio_clkdiv_multi
`default_nettype wire

// File: tb/tb_pio_clkdiv_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pio_clkdiv_multi                                        |
// | Description : Directed self-checking bench for pio_clkdiv_multi: a       |
// |               4-channel 16.8 instance and a 1-channel 4.8 instance.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pio_clkdiv_multi;

  localparam int ONE = 256;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pio_clkdiv_multi_if #(.NUM_CH(4), .INT_W(16), .FRAC_W(8)) bus ();
  pio_clkdiv_multi_if #(.NUM_CH(1), .INT_W(4),  .FRAC_W(8)) sbus ();

  pio_clkdiv_multi #(.NUM_CH(4), .INT_W(16), .FRAC_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pio_clkdiv_multi #(.NUM_CH(1), .INT_W(4), .FRAC_W(8)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Advance one active edge and settle; outputs then show that edge's result.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(input int ch, input logic [15:0] iv, input logic [7:0] fv);
    bus.div_int[ch*16 +: 16] = iv;
    bus.div_frac[ch*8 +: 8]  = fv;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    v = '0;
    tick();
    n_chk++;
    if (bus.penable !== 4'b0000 || sbus.penable !== 1'b0) begin
      $display("FAIL reset_state: penable=%b/%b expected 0000/0", bus.penable, sbus.penable);
      n_fail++;
    end
    reset = 1'b0;
    set_div(0, 16'd3, 8'd0);
    bus.restart[0] = 1'b1;
    tick();
    bus.restart[0] = 1'b0;
    bus.en[0]      = 1'b1;
    tick(); tick(); tick();
    n_chk++;
    if (bus.penable[0] !== 1'b1) begin
      $display("FAIL pre_reset_strobe: penable0=%b expected 1", bus.penable[0]);
      n_fail++;
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if (bus.penable[0] !== 1'b0) begin
      $display("FAIL async_reset: penable0=%b expected 0", bus.penable[0]);
      n_fail++;
    end
    set_div(0, 16'd1, 8'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      v = {v[30:0], bus.penable[0]};
    end
    n_chk++;
    if (v[4:0] !== 5'b11111) begin
      $display("FAIL div1_after_reset: got %b expected 11111", v[4:0]);
      n_fail++;
    end
  endtask

  task automatic test_int_div();
    int c0, c1, adj;
    logic prev;
    c0 = 0; c1 = 0; adj = 0; prev = 1'b0;
    set_div(1, 16'd2, 8'd0);
    bus.restart[1] = 1'b1;
    tick();
    bus.restart[1] = 1'b0;
    bus.en[1]      = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      c0 += int'(bus.penable[0]);
      c1 += int'(bus.penable[1]);
      if (bus.penable[1] && prev) adj++;
      prev = bus.penable[1];
    end
    n_chk++;
    if (c1 !== 50) begin
      $display("FAIL int2_count: got %0d expected 50", c1);
      n_fail++;
    end
    n_chk++;
    if (adj !== 0) begin
      $display("FAIL int2_width: got %0d wide strobes expected 0", adj);
      n_fail++;
    end
    n_chk++;
    if (c0 !== 100) begin
      $display("FAIL ch0_independent: got %0d expected 100", c0);
      n_fail++;
    end
  endtask

  task automatic test_frac_div();
    logic [31:0] v;
    int c;
    v = '0; c = 0;
    set_div(2, 16'd1, 8'd128);
    bus.restart[2] = 1'b1;
    tick();
    bus.restart[2] = 1'b0;
    bus.en[2]      = 1'b1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (k < 6) v = {v[30:0], bus.penable[2]};
      c += int'(bus.penable[2]);
    end
    n_chk++;
    if (v[5:0] !== 6'b011011) begin
      $display("FAIL frac1p5_pattern: got %b expected 011011", v[5:0]);
      n_fail++;
    end
    n_chk++;
    if (c !== 200) begin
      $display("FAIL frac1p5_count: got %0d expected 200", c);
      n_fail++;
    end
    c = 0;
    set_div(2, 16'd2, 8'd64);
    bus.restart[2] = 1'b1;
    tick();
    bus.restart[2] = 1'b0;
    for (int k = 0; k < 900; k++) begin
      tick();
      c += int'(bus.penable[2]);
    end
    n_chk++;
    if (c !== 400) begin
      $display("FAIL frac2p25_count: got %0d expected 400", c);
      n_fail++;
    end
  endtask

  task automatic test_max_div();
    logic [31:0] v;
    v = '0;
    sbus.div_int  = 4'd0;
    sbus.div_frac = 8'hFF;
    sbus.restart  = 1'b1;
    tick();
    sbus.restart = 1'b0;
    sbus.en      = 1'b1;
    for (int k = 0; k < 32; k++) begin
      tick();
      v = {v[30:0], sbus.penable[0]};
    end
    n_chk++;
    if (v !== 32'h0001_0001) begin
      $display("FAIL int0_max_div: got %h expected 00010001", v);
      n_fail++;
    end
    v = '0;
    sbus.restart = 1'b1;
    tick();
    sbus.restart = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      sbus.en = (k >= 9 && k <= 13) ? 1'b0 : 1'b1;
      tick();
      v = {v[30:0], sbus.penable[0]};
    end
    n_chk++;
    if (v[23:0] !== 24'h000008) begin
      $display("FAIL en_stall_stretch: got %h expected 000008", v[23:0]);
      n_fail++;
    end
  endtask

  task automatic test_update_restart();
    logic [31:0] v0, v1;
    v0 = '0; v1 = '0;
    set_div(3, 16'd3, 8'd0);
    bus.restart[3] = 1'b1;
    tick();
    bus.restart[3] = 1'b0;
    bus.en[3]      = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      if (k == 8) set_div(3, 16'd2, 8'd0);
      tick();
      v0 = {v0[30:0], bus.penable[3]};
    end
    n_chk++;
    if (v0[13:0] !== 14'b00100100101010) begin
      $display("FAIL div_update: got %b expected 00100100101010", v0[13:0]);
      n_fail++;
    end
    v0 = '0;
    set_div(0, 16'd5, 8'd0);
    set_div(1, 16'd5, 8'd0);
    bus.restart[1:0] = 2'b11;
    tick();
    bus.restart[1:0] = 2'b00;
    for (int k = 0; k < 20; k++) begin
      tick();
      v0 = {v0[30:0], bus.penable[0]};
      v1 = {v1[30:0], bus.penable[1]};
    end
    n_chk++;
    if (v0[19:0] !== 20'b00001000010000100001) begin
      $display("FAIL sync_restart_ch0: got %b expected 00001000010000100001", v0[19:0]);
      n_fail++;
    end
    n_chk++;
    if (v1[19:0] !== 20'b00001000010000100001) begin
      $display("FAIL sync_restart_ch1: got %b expected 00001000010000100001", v1[19:0]);
      n_fail++;
    end
    set_div(2, 16'd1, 8'd0);
    bus.restart[2] = 1'b1;
    bus.en[2]      = 1'b1;
    tick();
    n_chk++;
    if (bus.penable[2] !== 1'b0) begin
      $display("FAIL restart_over_en: penable2=%b expected 0", bus.penable[2]);
      n_fail++;
    end
    bus.restart[2] = 1'b0;
    tick();
    n_chk++;
    if (bus.penable[2] !== 1'b1) begin
      $display("FAIL run_after_restart: penable2=%b expected 1", bus.penable[2]);
      n_fail++;
    end
  endtask

`ifdef PIO_CLKDIV_PHASE_EN
  task automatic test_phase();
    logic [31:0] v0, v1;
    v0 = '0; v1 = '0;
    set_div(0, 16'd4, 8'd0);
    set_div(1, 16'd4, 8'd0);
    bus.phase_init[0*24 +: 24] = 24'd0;
    bus.phase_init[1*24 +: 24] = 24'(2*ONE);
    bus.restart[1:0] = 2'b11;
    tick();
    bus.restart[1:0] = 2'b00;
    bus.en[1:0]      = 2'b11;
    for (int k = 0; k < 12; k++) begin
      tick();
      v0 = {v0[30:0], bus.penable[0]};
      v1 = {v1[30:0], bus.penable[1]};
    end
    n_chk++;
    if (v0[11:0] !== 12'b000100010001) begin
      $display("FAIL phase_ch0: got %b expected 000100010001", v0[11:0]);
      n_fail++;
    end
    n_chk++;
    if (v1[11:0] !== 12'b010001000100) begin
      $display("FAIL phase_ch1: got %b expected 010001000100", v1[11:0]);
      n_fail++;
    end
    v0 = '0;
    bus.phase_init[0*24 +: 24] = 24'(9*ONE);
    bus.restart[0] = 1'b1;
    tick();
    bus.restart[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      v0 = {v0[30:0], bus.penable[0]};
    end
    n_chk++;
    if (v0[4:0] !== 5'b10001) begin
      $display("FAIL phase_clamp: got %b expected 10001", v0[4:0]);
      n_fail++;
    end
  endtask
`endif

  initial begin
    bus.en       = '0;
    bus.restart  = '0;
    bus.div_int  = '0;
    bus.div_frac = '0;
    sbus.en       = '0;
    sbus.restart  = '0;
    sbus.div_int  = '0;
    sbus.div_frac = '0;
`ifdef PIO_CLKDIV_PHASE_EN
    bus.phase_init  = '0;
    sbus.phase_init = '0;
`endif
    #1;
    test_reset();
    test_int_div();
    test_frac_div();
    test_max_div();
    test_update_restart();
`ifdef PIO_CLKDIV_PHASE_EN
    test_phase();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_pio_clkdiv_multi
`default_nettype wire
